alu_io_publisher: RTL

- User-project-side driver for the ALU result pin map on mprj_io[26:0]: two 8-bit ALU results, two carry flags, an 8-bit sequence tag and a strobe.
- Accepts result pairs from the ALU datapath over a valid/ready handshake and buffers them in a small FIFO.
- Presents each pair on the pads for a fixed, strobe-qualified hold window so the off-chip monitor can sample it reliably.

---
 rtl/alu_io_publisher_if.sv | 23 ++
 rtl/alu_io_publisher.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_io_publisher_if.sv
// Handshake and pad bundle between the ALU datapath/pad ring and alu_io_publisher.
// master = ALU side driving result pairs; slave = the publisher itself.
interface alu_io_publisher_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  alu1_out;
   logic [7:0]  alu2_out;
   logic        carry1;
   logic        carry2;
   logic [26:0] io_out;
   logic [26:0] io_oeb;
   logic        busy;

   modport master (
      output in_valid, alu1_out, alu2_out, carry1, carry2,
      input  in_ready, io_out, io_oeb, busy
   );

   modport slave (
      input  in_valid, alu1_out, alu2_out, carry1, carry2,
      output in_ready, io_out, io_oeb, busy
   );
endinterface

// File: rtl/alu_io_publisher.sv
// Buffers ALU result pairs in a FIFO and publishes each on mprj_io[26:0] with a timed strobe.
// Optional macro ALU_IO_PARITY_EN: io_out[25] = even parity of io_out[17:0], 7-bit tag on [24:18].
module alu_io_publisher #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic              clock,
   input  logic              resetb,
   alu_io_publisher_if.slave bus
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
`ifdef ALU_IO_PARITY_EN
   localparam int unsigned TAG_W = 7;
   localparam int unsigned ENT_W = 19;
`else
   localparam int unsigned TAG_W = 8;
   localparam int unsigned ENT_W = 18;
`endif
   localparam logic [3:0]       HOLD_INIT = 4'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          hold_q, hold_d;
   logic [TAG_W-1:0]    seq_q, seq_d;
   logic [TAG_W-1:0]    tag_q;
   logic [17:0]         data_q;
   logic                strobe_q;
   logic                busy_q;
   logic                en_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
   logic                in_ready_s, push_s, pop_s;
   logic [17:0]         payload_s;
   logic [ENT_W-1:0]    wr_entry_s;
   logic [ENT_W-1:0]    head_s;

`ifdef ALU_IO_PARITY_EN
   logic                par_q;

   function automatic logic even_parity18(input logic [17:0] v);
      return ^v;
   endfunction
`endif

   // Ready only after the pads are enabled and only from the registered count.
   assign in_ready_s = en_q & (count_q < FULL_CNT);
   assign push_s     = bus.in_valid & in_ready_s;
   assign pop_s      = (count_q != CNT_ZERO) & ((state_q == ST_IDLE) | (state_q == ST_GAP));
   assign payload_s  = {bus.carry2, bus.carry1, bus.alu2_out, bus.alu1_out};
   assign head_s     = mem_q[rd_ptr_q];

`ifdef ALU_IO_PARITY_EN
   assign wr_entry_s = {even_parity18(payload_s), payload_s};
`else
   assign wr_entry_s = payload_s;
`endif

   // FIFO occupancy next value; a pop and push in the same cycle cancel out.
   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Publisher sequencing: SETUP -> HOLD (strobe) -> GAP, popping on entry to SETUP.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      seq_d   = seq_q;
      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_d = ST_HOLD;
            hold_d  = HOLD_INIT;
         end
         ST_HOLD: begin
            if (hold_q == 4'd0) begin
               state_d = ST_GAP;
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         ST_GAP: begin
            seq_d = seq_q + TAG_W'(1);
            if (pop_s) begin
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state plus every pad-facing register; the tag takes the post-increment count.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q  <= ST_IDLE;
         hold_q   <= 4'd0;
         seq_q    <= {TAG_W{1'b0}};
         tag_q    <= {TAG_W{1'b0}};
         data_q   <= 18'd0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
`ifdef ALU_IO_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         en_q     <= 1'b1;
         state_q  <= state_d;
         hold_q   <= hold_d;
         seq_q    <= seq_d;
         strobe_q <= (state_d == ST_HOLD);
         busy_q   <= (state_d != ST_IDLE) | (count_d != CNT_ZERO);
         if (pop_s) begin
            data_q <= head_s[17:0];
            tag_q  <= seq_d;
`ifdef ALU_IO_PARITY_EN
            par_q  <= head_s[18];
`endif
         end else begin
            data_q <= data_q;
            tag_q  <= tag_q;
         end
      end
   end

   // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= CNT_ZERO;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= {ENT_W{1'b0}};
         end
      end else begin
         count_q <= count_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

   assign bus.in_ready = in_ready_s;
   assign bus.busy     = busy_q;
   assign bus.io_oeb   = {27{~en_q}};
`ifdef ALU_IO_PARITY_EN
   assign bus.io_out   = {strobe_q, par_q, tag_q, data_q};
`else
   assign bus.io_out   = {strobe_q, tag_q, data_q};
`endif

endmodule
